ps2_keypad: RTL

//  PS/2 keyboard receiver and make-code decoder feeding the piece-move stage.

---
 rtl/ps2_keypad.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ps2_keypad.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered frame capture
// with E0/F0 prefix handling; emits one press strobe per make code.
module ps2_keypad #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       kb_reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       ext,
    output logic       press,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          clk_m, clk_s, dat_m, dat_s;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic          ext_f, brk_f;
    logic          fall;

    // Strobe on the cycle the filtered clock is about to flip 1->0.
    assign fall = filt && !clk_s && (fcnt == FMAX);

    always_ff @(posedge clock) begin
        if (kb_reset) begin
            clk_m <= 1'b1;
            clk_s <= 1'b1;
            dat_m <= 1'b1;
            dat_s <= 1'b1;
            filt  <= 1'b1;
            fcnt  <= '0;
        end else begin
            clk_m <= ps2_clk;
            clk_s <= clk_m;
            dat_m <= ps2_data;
            dat_s <= dat_m;
            if (clk_s == filt) begin
                fcnt <= '0;
            end else if (fcnt == FMAX) begin
                filt <= clk_s;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (kb_reset) begin
            state  <= IDLE;
            tcnt   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            ext_f  <= 1'b0;
            brk_f  <= 1'b0;
            code   <= 8'h00;
            ext    <= 1'b0;
            press  <= 1'b0;
            err    <= 1'b0;
        end else begin
            press <= 1'b0;
            err   <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!dat_s) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_s;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!(dat_s && (^{shreg, par}))) begin
                            err   <= 1'b1;
                            ext_f <= 1'b0;
                            brk_f <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            ext_f <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_f <= 1'b1;
                        end else begin
                            if (!brk_f) begin
                                code  <= shreg;
                                ext   <= ext_f;
                                press <= 1'b1;
                            end
                            ext_f <= 1'b0;
                            brk_f <= 1'b0;
                        end
                    end
                endcase
            end else if (state != IDLE) begin
                // Device went quiet mid-frame: abandon it.
                if (tcnt == TMAX) begin
                    state <= IDLE;
                    err   <= 1'b1;
                    shreg <= '0;
                    ext_f <= 1'b0;
                    brk_f <= 1'b0;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule
